// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared constants and helpers for the multi-channel debouncer.
//   clog2()          : ceiling log2, used to size counters from parameters
//   DEF_WIDTH        : default channel count
//   DEF_DIV          : default prescaler divide ratio
//   DEF_STABLE       : default number of sample ticks to qualify a change
//   DEF_SYNC_STAGES  : default synchroniser depth
// -----------------------------------------------------------------------------
package debounce_pkg;

    localparam int DEF_WIDTH       = 2;
    localparam int DEF_DIV         = 1;
    localparam int DEF_STABLE      = 3;
    localparam int DEF_SYNC_STAGES = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// -----------------------------------------------------------------------------
// debounce_chan
// One debounce channel: input synchroniser, stability counter, debounced
// output bit and (optionally) registered edge pulses.
// Optional feature macro: DEBOUNCE_EDGE_EN (adds rise/fall ports).
// Ports:
//   clk   in   system clock, rising edge
//   clr   in   asynchronous active-low reset
//   inp   in   raw asynchronous input
//   tick  in   shared sample strobe from the prescaler
//   outp  out  debounced level
//   rise  out  one-cycle pulse with the 0->1 update of outp (DEBOUNCE_EDGE_EN)
//   fall  out  one-cycle pulse with the 1->0 update of outp (DEBOUNCE_EDGE_EN)
// -----------------------------------------------------------------------------
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE      = DEF_STABLE,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic clr,
    input  logic inp,
    input  logic tick,
    output logic outp
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    localparam int CW = clog2(STABLE + 1);
    localparam logic [CW-1:0] TERM = CW'(STABLE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CW-1:0]          cnt;
    logic                   done;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], inp};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // The qualifying tick that lets outp take the new level.
    assign done = (sync != outp) && tick && (cnt == TERM);

    // Any sample that agrees with outp restarts the window, tick or not.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt  <= '0;
            outp <= 1'b0;
        end else if (sync == outp) begin
            cnt <= '0;
        end else if (done) begin
            cnt  <= '0;
            outp <= sync;
        end else if (tick) begin
            cnt <= cnt + CW'(1);
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    // Pulses are registered on the same edge that updates outp.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= done & sync;
            fall <= done & ~sync;
        end
    end
`endif

endmodule

// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
// Multi-channel switch/button debouncer. A shared prescaler produces a sample
// tick every DIV clocks; each channel only follows its input after the
// synchronised value has differed from the output for STABLE ticks in a row.
// Optional feature macro: DEBOUNCE_EDGE_EN (adds rise/fall edge pulse ports).
// Ports:
//   clk   in   system clock, rising edge
//   clr   in   asynchronous active-low reset
//   inp   in   [WIDTH] raw bouncy inputs
//   outp  out  [WIDTH] debounced levels
//   tick  out  one-cycle sample strobe
//   rise  out  [WIDTH] 0->1 pulses (DEBOUNCE_EDGE_EN)
//   fall  out  [WIDTH] 1->0 pulses (DEBOUNCE_EDGE_EN)
// -----------------------------------------------------------------------------
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DIV         = DEF_DIV,
    parameter int STABLE      = DEF_STABLE,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] inp,
    output logic [WIDTH-1:0] outp,
    output logic             tick
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    localparam int PW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

    logic [PW-1:0] pcnt;

    // tick is registered so it is low during reset; with DIV=1 pcnt stays 0
    // and tick is high every cycle after release.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (pcnt == PLAST);
            pcnt <= (pcnt == PLAST) ? '0 : pcnt + PW'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_chan #(
            .STABLE      (STABLE),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk  (clk),
            .clr  (clr),
            .inp  (inp[i]),
            .tick (tick),
            .outp (outp[i])
`ifdef DEBOUNCE_EDGE_EN
            ,
            .rise (rise[i]),
            .fall (fall[i])
`endif
        );
    end

endmodule
